// File: rtl/tamagotchi_mood_fsm_if.sv
// rtl/tamagotchi_mood_fsm_if.sv - button inputs and mood outputs of the tamagotchi mood FSM
interface tamagotchi_mood_fsm_if;
    logic       btn_feed;
    logic       btn_play;
    logic       btn_heal;
    logic [2:0] visua;
    logic       mood_change;

    modport master (output btn_feed, btn_play, btn_heal, input visua, mood_change);
    modport slave  (input btn_feed, btn_play, btn_heal, output visua, mood_change);
endinterface

// File: rtl/tamagotchi_mood_fsm.sv
// rtl/tamagotchi_mood_fsm.sv - pet stat keeper and registered mood selector
// Define FAST_TICK_EN to make the life tick divide by 16 instead of TICK_DIV.
module tamagotchi_mood_fsm #(
    parameter int TICK_DIV     = 125000000,
    parameter int STEP         = 4,
    parameter int CARINO_TICKS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    tamagotchi_mood_fsm_if.slave io
);
    localparam logic [2:0] MOOD_IDLE      = 3'd0;
    localparam logic [2:0] MOOD_TRISTE    = 3'd1;
    localparam logic [2:0] MOOD_CARINO    = 3'd2;
    localparam logic [2:0] MOOD_DEPRIMIDO = 3'd3;
    localparam logic [2:0] MOOD_MUERTO    = 3'd4;

`ifdef FAST_TICK_EN
    localparam int DIV = 16;
`else
    localparam int DIV = TICK_DIV;
`endif
    localparam int CW = (CARINO_TICKS < 1) ? 1 : $clog2(CARINO_TICKS + 1);

    logic [31:0]   presc;
    logic          tick;
    logic          prev_feed, prev_play, prev_heal;
    logic          armed;
    logic          feed_edge, play_edge, heal_edge;
    logic [3:0]    hunger, happiness, health;
    logic [3:0]    n_hunger, n_happiness, n_health;
    logic [CW-1:0] carino, n_carino;
    logic [2:0]    mood;
    logic          dead;

    function automatic logic [3:0] sat(input logic [3:0] v, input int d);
        int s;
        s = int'(v) + d;
        if (s > 15) s = 15;
        if (s < 0)  s = 0;
        return s[3:0];
    endfunction

    assign tick = (presc == 32'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 32'd1;
    end

    // armed stays low for the first cycle after reset so a level held across release is not an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_feed <= 1'b0;
            prev_play <= 1'b0;
            prev_heal <= 1'b0;
            armed     <= 1'b0;
        end else begin
            prev_feed <= io.btn_feed;
            prev_play <= io.btn_play;
            prev_heal <= io.btn_heal;
            armed     <= 1'b1;
        end
    end

    assign feed_edge = armed & io.btn_feed & ~prev_feed;
    assign play_edge = armed & io.btn_play & ~prev_play;
    assign heal_edge = armed & io.btn_heal & ~prev_heal;
    assign dead      = (health == 4'd0);

    always_comb begin
        n_hunger    = hunger;
        n_happiness = happiness;
        n_health    = health;
        n_carino    = carino;
        if (tick) begin
            n_hunger    = sat(hunger, 1);
            n_happiness = sat(happiness, -1);
            if (hunger == 4'd15) n_health = sat(health, -1);
            if (carino != '0)    n_carino = carino - CW'(1);
        end
        if (feed_edge) n_hunger = sat(n_hunger, -STEP);
        if (heal_edge) n_health = sat(n_health, STEP);
        if (play_edge) begin
            n_happiness = sat(n_happiness, STEP);
            n_carino    = CW'(CARINO_TICKS);
        end
    end

    // health only rises through heal, so freezing on health==0 keeps MUERTO absorbing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hunger    <= 4'd0;
            happiness <= 4'd15;
            health    <= 4'd15;
            carino    <= '0;
        end else if (!dead) begin
            hunger    <= n_hunger;
            happiness <= n_happiness;
            health    <= n_health;
            carino    <= n_carino;
        end
    end

    always_comb begin
        mood = MOOD_IDLE;
        if (health == 4'd0)                              mood = MOOD_MUERTO;
        else if (happiness <= 4'd3 && hunger >= 4'd12)   mood = MOOD_DEPRIMIDO;
        else if (happiness <= 4'd5 || hunger >= 4'd10)   mood = MOOD_TRISTE;
        else if (carino != '0)                           mood = MOOD_CARINO;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io.visua       <= MOOD_IDLE;
            io.mood_change <= 1'b0;
        end else begin
            io.visua       <= mood;
            io.mood_change <= (mood != io.visua);
        end
    end
endmodule

// File: tb/tb_tamagotchi_mood_fsm.sv
// tb/tb_tamagotchi_mood_fsm.sv - scoreboard bench for tamagotchi_mood_fsm with a behavioural pet model
module tb_tamagotchi_mood_fsm;
`ifdef FAST_TICK_EN
    localparam int DIV = 16;
`else
    localparam int DIV = 8;
`endif
    localparam int STEP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tamagotchi_mood_fsm_if io();

    tamagotchi_mood_fsm #(.TICK_DIV(8), .STEP(STEP), .CARINO_TICKS(3)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #4 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc;
    int exp_q[$];

    int m_hu, m_ha, m_he, m_ca, m_n, m_vis, m_mood, m_hu_before;
    bit m_first, m_pf, m_pp, m_ph, m_tick, m_ef, m_ep, m_eh;
    int e;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int clamp(input int v);
        return (v > 15) ? 15 : ((v < 0) ? 0 : v);
    endfunction

    function automatic int ref_mood(input int hu, input int ha, input int he, input int ca);
        if (he == 0)              return 4;
        if (ha <= 3 && hu >= 12)  return 3;
        if (ha <= 5 || hu >= 10)  return 1;
        if (ca > 0)               return 2;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Reference pet: one life step per clock, stats as plain integers.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hu = 0; m_ha = 15; m_he = 15; m_ca = 0; m_n = 0; m_vis = 0;
            m_first = 1; m_pf = 0; m_pp = 0; m_ph = 0;
            exp_q.delete();
        end else begin
            m_mood = ref_mood(m_hu, m_ha, m_he, m_ca);
            if (m_mood != m_vis) begin
                exp_q.push_back(m_mood);
                m_vis = m_mood;
            end
            m_tick = ((m_n % DIV) == DIV - 1);
            m_n++;
            m_ef = !m_first && io.btn_feed && !m_pf;
            m_ep = !m_first && io.btn_play && !m_pp;
            m_eh = !m_first && io.btn_heal && !m_ph;
            if (m_he != 0) begin
                if (m_tick) begin
                    m_hu_before = m_hu;
                    m_hu = clamp(m_hu + 1);
                    m_ha = clamp(m_ha - 1);
                    if (m_hu_before == 15) m_he = clamp(m_he - 1);
                    if (m_ca > 0) m_ca--;
                end
                if (m_ef) m_hu = clamp(m_hu - STEP);
                if (m_eh) m_he = clamp(m_he + STEP);
                if (m_ep) begin
                    m_ha = clamp(m_ha + STEP);
                    m_ca = 3;
                end
            end
            m_pf = io.btn_feed; m_pp = io.btn_play; m_ph = io.btn_heal;
            m_first = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (io.mood_change) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_mood_change: visua=%0d, expected no pulse (t=%0t)", io.visua, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("mood_change_visua", int'(io.visua), e);
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_total++;
                $display("FAIL missing_mood_change: visua=%0d, expected pulse to %0d (t=%0t)", io.visua, e, $time);
            end
        end
    end

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        io.btn_feed = 1'b0;
        io.btn_play = 1'b0;
        io.btn_heal = 1'b0;

        // reset values, held button across release, five idle ticks
        repeat (3) @(negedge clk);
        chk("reset_visua", int'(io.visua), 0);
        chk("reset_mood_change", int'(io.mood_change), 0);
        io.btn_play = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        goto(4);
        chk("held_play_ignored", int'(io.visua), 0);
        io.btn_play = 1'b0;
        goto(5 * DIV + 2);
        chk("five_ticks_idle", int'(io.visua), 0);

        // play at tick 1 -> CARINO for three ticks
        do_reset();
        goto(DIV + 1);
        io.btn_play = 1'b1;
        goto(DIV + 2);
        io.btn_play = 1'b0;
        goto(DIV + 4);
        chk("play_carino", int'(io.visua), 2);
        goto(4 * DIV - 1);
        chk("carino_held", int'(io.visua), 2);
        goto(4 * DIV + 2);
        chk("carino_expired", int'(io.visua), 0);

        // neglect: TRISTE, DEPRIMIDO, MUERTO, then buttons ignored
        do_reset();
        goto(9 * DIV + 2);
        chk("tick9_idle", int'(io.visua), 0);
        goto(10 * DIV + 2);
        chk("tick10_triste", int'(io.visua), 1);
        goto(11 * DIV + 2);
        chk("tick11_triste", int'(io.visua), 1);
        goto(12 * DIV + 2);
        chk("tick12_deprimido", int'(io.visua), 3);
        goto(29 * DIV + 2);
        chk("tick29_deprimido", int'(io.visua), 3);
        goto(30 * DIV + 2);
        chk("tick30_muerto", int'(io.visua), 4);
        io.btn_feed = 1'b1; io.btn_play = 1'b1; io.btn_heal = 1'b1;
        goto(30 * DIV + 102);
        chk("muerto_absorbing", int'(io.visua), 4);
        io.btn_feed = 1'b0; io.btn_play = 1'b0; io.btn_heal = 1'b0;

        // feed edge coincident with a tick at hunger 15: tick first, then feed
        do_reset();
        goto(16 * DIV - 1);
        chk("pre_feed_deprimido", int'(io.visua), 3);
        io.btn_feed = 1'b1;
        goto(16 * DIV + 2);
        chk("tick_then_feed", int'(io.visua), 1);
        io.btn_feed = 1'b0;

        // held heal counts once, then reset aborts MUERTO
        do_reset();
        goto(29 * DIV + 2);
        io.btn_heal = 1'b1;
        goto(29 * DIV + 102);
        io.btn_heal = 1'b0;
        goto(35 * DIV);
        chk("heal_once_then_dies", int'(io.visua), 4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_in_muerto_visua", int'(io.visua), 0);
        chk("reset_in_muerto_pulse", int'(io.mood_change), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        goto(5 * DIV + 2);
        chk("post_reset_stats", int'(io.visua), 0);

        // randomized button activity against the reference pet
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                if ($urandom_range(0, 4) == 0) io.btn_feed = ~io.btn_feed;
                if ($urandom_range(0, 6) == 0) io.btn_play = ~io.btn_play;
                if ($urandom_range(0, 5) == 0) io.btn_heal = ~io.btn_heal;
                if (i % 50 == 49) chk("visua_track", int'(io.visua), m_vis);
            end
            io.btn_feed = 1'b0; io.btn_play = 1'b0; io.btn_heal = 1'b0;
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
